// File: rtl/pulse_cmd_rx.sv
// UART (8N1) command receiver and 12-byte parameter frame parser.
// Parameter outputs only change on a frame whose checksum verifies.
module pulse_cmd_rx #(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter int unsigned TIMEOUT_CLKS = 120000,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter logic [23:0] DEF_PER      = 24'd10000,
    parameter logic [15:0] DEF_P1       = 16'd15,
    parameter logic [15:0] DEF_DEL      = 16'd100,
    parameter logic [15:0] DEF_P2       = 16'd30,
    parameter logic        DEF_CP       = 1'b1,
    parameter logic        DEF_BL       = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        rxd,
    output logic [23:0] per,
    output logic [15:0] p1wid,
    output logic [15:0] del,
    output logic [15:0] p2wid,
    output logic        cp,
    output logic        bl,
    output logic        rx_done,
    output logic        frame_err
);
    localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CNT_W-1:0]  HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDLE_W-1:0] TO_M1   = IDLE_W'(TIMEOUT_CLKS - 1);

    typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_e;
    typedef enum logic [1:0] {P_HUNT, P_PAYLOAD, P_CHECK} parse_e;

    logic             rx_s1_q, rx_s2_q, rx_prev_q;
    uart_e            uart_q, uart_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             bv_q, bv_d, serr_q, serr_d;

    parse_e            p_q, p_d;
    logic [3:0]        idx_q, idx_d;
    logic [7:0]        xor_q, xor_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [23:0]       per_sh_q, per_sh_d;
    logic [15:0]       p1_sh_q, p1_sh_d, del_sh_q, del_sh_d, p2_sh_q, p2_sh_d;
    logic [1:0]        fl_sh_q, fl_sh_d;
    logic [23:0]       per_q, per_d;
    logic [15:0]       p1_q, p1_d, del_q, del_d, p2_q, p2_d;
    logic              cp_q, cp_d, bl_q, bl_d, done_q, done_d, ferr_q, ferr_d;

    always_comb begin
        uart_d  = uart_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        bv_d    = 1'b0;
        serr_d  = 1'b0;
        case (uart_q)
            U_IDLE: begin
                cnt_d = '0;
                if (rx_prev_q && !rx_s2_q) uart_d = U_START;
            end
            U_START: if (cnt_q == HALF_M1) begin
                cnt_d  = '0;
                bit_d  = '0;
                uart_d = rx_s2_q ? U_IDLE : U_DATA;
            end
            U_DATA: if (cnt_q == FULL_M1) begin
                cnt_d   = '0;
                shift_d = {rx_s2_q, shift_q[7:1]};
                bit_d   = bit_q + 1'b1;
                if (bit_q == 3'd7) uart_d = U_STOP;
            end
            U_STOP: if (cnt_q == FULL_M1) begin
                cnt_d  = '0;
                uart_d = U_IDLE;
                if (rx_s2_q) bv_d = 1'b1;
                else         serr_d = 1'b1;
            end
            default: uart_d = U_IDLE;
        endcase
    end

    // A received byte takes priority over a timeout expiring in the same cycle.
    always_comb begin
        p_d      = p_q;
        idx_d    = idx_q;
        xor_d    = xor_q;
        idle_d   = (p_q == P_HUNT) ? '0 : idle_q + 1'b1;
        per_sh_d = per_sh_q;
        p1_sh_d  = p1_sh_q;
        del_sh_d = del_sh_q;
        p2_sh_d  = p2_sh_q;
        fl_sh_d  = fl_sh_q;
        per_d    = per_q;
        p1_d     = p1_q;
        del_d    = del_q;
        p2_d     = p2_q;
        cp_d     = cp_q;
        bl_d     = bl_q;
        done_d   = 1'b0;
        ferr_d   = 1'b0;
        if (bv_q) begin
            idle_d = '0;
            case (p_q)
                P_HUNT: if (shift_q == SYNC_BYTE) begin
                    xor_d = '0;
                    idx_d = '0;
                    p_d   = P_PAYLOAD;
                end
                P_PAYLOAD: begin
                    xor_d = xor_q ^ shift_q;
                    case (idx_q)
                        4'd0: per_sh_d[23:16] = shift_q;
                        4'd1: per_sh_d[15:8]  = shift_q;
                        4'd2: per_sh_d[7:0]   = shift_q;
                        4'd3: p1_sh_d[15:8]   = shift_q;
                        4'd4: p1_sh_d[7:0]    = shift_q;
                        4'd5: del_sh_d[15:8]  = shift_q;
                        4'd6: del_sh_d[7:0]   = shift_q;
                        4'd7: p2_sh_d[15:8]   = shift_q;
                        4'd8: p2_sh_d[7:0]    = shift_q;
                        4'd9: fl_sh_d         = shift_q[1:0];
                        default: ;
                    endcase
                    if (idx_q == 4'd9) p_d = P_CHECK;
                    else               idx_d = idx_q + 1'b1;
                end
                P_CHECK: begin
                    p_d = P_HUNT;
                    if (shift_q == xor_q) begin
                        per_d  = per_sh_q;
                        p1_d   = p1_sh_q;
                        del_d  = del_sh_q;
                        p2_d   = p2_sh_q;
                        cp_d   = fl_sh_q[0];
                        bl_d   = fl_sh_q[1];
                        done_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
                default: p_d = P_HUNT;
            endcase
        end else if (serr_q) begin
            p_d    = P_HUNT;
            idle_d = '0;
            ferr_d = (p_q != P_HUNT);
        end else if (p_q != P_HUNT && idle_q == TO_M1) begin
            p_d    = P_HUNT;
            idle_d = '0;
            ferr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
            uart_q    <= U_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            bv_q      <= 1'b0;
            serr_q    <= 1'b0;
            p_q       <= P_HUNT;
            idx_q     <= '0;
            xor_q     <= '0;
            idle_q    <= '0;
            per_sh_q  <= '0;
            p1_sh_q   <= '0;
            del_sh_q  <= '0;
            p2_sh_q   <= '0;
            fl_sh_q   <= '0;
            per_q     <= DEF_PER;
            p1_q      <= DEF_P1;
            del_q     <= DEF_DEL;
            p2_q      <= DEF_P2;
            cp_q      <= DEF_CP;
            bl_q      <= DEF_BL;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rx_s1_q   <= rxd;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            uart_q    <= uart_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            bv_q      <= bv_d;
            serr_q    <= serr_d;
            p_q       <= p_d;
            idx_q     <= idx_d;
            xor_q     <= xor_d;
            idle_q    <= idle_d;
            per_sh_q  <= per_sh_d;
            p1_sh_q   <= p1_sh_d;
            del_sh_q  <= del_sh_d;
            p2_sh_q   <= p2_sh_d;
            fl_sh_q   <= fl_sh_d;
            per_q     <= per_d;
            p1_q      <= p1_d;
            del_q     <= del_d;
            p2_q      <= p2_d;
            cp_q      <= cp_d;
            bl_q      <= bl_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
        end
    end

    assign per       = per_q;
    assign p1wid     = p1_q;
    assign del       = del_q;
    assign p2wid     = p2_q;
    assign cp        = cp_q;
    assign bl        = bl_q;
    assign rx_done   = done_q;
    assign frame_err = ferr_q;
endmodule

// File: tb/tb_pulse_cmd_rx.sv
// Bench for pulse_cmd_rx: serial frames in, committed parameter sets checked
// against a queue of expected strobe events.
module tb_pulse_cmd_rx;
    localparam int unsigned CPB = 8;
    localparam int unsigned TO  = 400;
    localparam logic [23:0] D_PER = 24'd10000;
    localparam logic [15:0] D_P1  = 16'd15;
    localparam logic [15:0] D_DEL = 16'd100;
    localparam logic [15:0] D_P2  = 16'd30;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        rxd = 1'b1;
    logic [23:0] per;
    logic [15:0] p1wid, del, p2wid;
    logic        cp, bl, rx_done, frame_err;

    pulse_cmd_rx #(
        .CLKS_PER_BIT(CPB),
        .TIMEOUT_CLKS(TO)
    ) dut (
        .clk(clk), .resetn(resetn), .rxd(rxd),
        .per(per), .p1wid(p1wid), .del(del), .p2wid(p2wid),
        .cp(cp), .bl(bl), .rx_done(rx_done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_done;
        logic [23:0] per;
        logic [15:0] p1, del, p2;
        logic        cp, bl;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    // committed parameter set as the host would believe it to be
    logic [23:0] m_per;
    logic [15:0] m_p1, m_del, m_p2;
    logic        m_cp, m_bl;

    task automatic model_reset();
        m_per = D_PER; m_p1 = D_P1; m_del = D_DEL; m_p2 = D_P2;
        m_cp = 1'b1; m_bl = 1'b1;
    endtask

    task automatic check_outputs(input string name);
        checks++;
        if (per !== m_per || p1wid !== m_p1 || del !== m_del || p2wid !== m_p2 ||
            cp !== m_cp || bl !== m_bl) begin
            errors++;
            $display("FAIL %s: got per=%0d p1=%0d del=%0d p2=%0d cp=%b bl=%b, want per=%0d p1=%0d del=%0d p2=%0d cp=%b bl=%b",
                     name, per, p1wid, del, p2wid, cp, bl, m_per, m_p1, m_del, m_p2, m_cp, m_bl);
        end
    endtask

    always @(negedge clk) begin
        if (resetn && (rx_done || frame_err)) begin
            exp_t e;
            checks++;
            if (rx_done && frame_err) begin
                errors++;
                $display("FAIL strobe_exclusive: rx_done=1 frame_err=1, want at most one");
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: rx_done=%b frame_err=%b, want none", rx_done, frame_err);
            end else begin
                e = exp_q.pop_front();
                if (rx_done !== e.is_done) begin
                    errors++;
                    $display("FAIL strobe_kind: got rx_done=%b, want rx_done=%b", rx_done, e.is_done);
                end
                checks++;
                if (per !== e.per || p1wid !== e.p1 || del !== e.del || p2wid !== e.p2 ||
                    cp !== e.cp || bl !== e.bl) begin
                    errors++;
                    $display("FAIL strobe_values: got per=%0d p1=%0d del=%0d p2=%0d cp=%b bl=%b, want per=%0d p1=%0d del=%0d p2=%0d cp=%b bl=%b",
                             per, p1wid, del, p2wid, cp, bl, e.per, e.p1, e.del, e.p2, e.cp, e.bl);
                end
            end
        end
    end

    task automatic idle(input int unsigned n);
        rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit good_stop);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = good_stop;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
        if (!good_stop) repeat (CPB) @(negedge clk);
    endtask

    function automatic logic [7:0] pl_byte(input logic [79:0] pl, input int i);
        return pl[79 - 8*i -: 8];
    endfunction

    function automatic logic [7:0] checksum(input logic [79:0] pl);
        logic [7:0] x = '0;
        for (int i = 0; i < 10; i++) x ^= pl_byte(pl, i);
        return x;
    endfunction

    task automatic send_frame(input logic [79:0] pl, input logic [7:0] flip);
        send_byte(8'hA5, 1'b1);
        for (int i = 0; i < 10; i++) send_byte(pl_byte(pl, i), 1'b1);
        send_byte(checksum(pl) ^ flip, 1'b1);
    endtask

    task automatic push_err();
        exp_t e;
        e.is_done = 1'b0; e.per = m_per; e.p1 = m_p1; e.del = m_del; e.p2 = m_p2;
        e.cp = m_cp; e.bl = m_bl;
        exp_q.push_back(e);
    endtask

    task automatic good_frame(input logic [23:0] fp, input logic [15:0] f1, input logic [15:0] fd,
                              input logic [15:0] f2, input logic [7:0] fl);
        exp_t e;
        m_per = fp; m_p1 = f1; m_del = fd; m_p2 = f2; m_cp = fl[0]; m_bl = fl[1];
        e.is_done = 1'b1; e.per = m_per; e.p1 = m_p1; e.del = m_del; e.p2 = m_p2;
        e.cp = m_cp; e.bl = m_bl;
        exp_q.push_back(e);
        send_frame({fp, f1, fd, f2, fl}, 8'h00);
    endtask

    task automatic bad_ck_frame(input logic [79:0] pl, input logic [7:0] flip);
        push_err();
        send_frame(pl, flip);
    endtask

    initial begin
        logic [79:0] pl;
        model_reset();
        repeat (5) @(negedge clk);
        resetn = 1'b1;
        idle(20);

        check_outputs("reset_values");
        checks++;
        if (rx_done !== 1'b0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobes: rx_done=%b frame_err=%b, want 0 0", rx_done, frame_err);
        end

        good_frame(24'd100000, 16'd30, 16'd200, 16'd60, 8'h03);
        idle(10);
        check_outputs("plan_frame");

        pl = {24'h0186A0, 16'd30, 16'd200, 16'd60, 8'h03};
        bad_ck_frame(pl, 8'h01);
        idle(10);
        check_outputs("bad_checksum_holds");

        good_frame(24'd5000, 16'd7, 16'd50, 16'd14, 8'h00);
        idle(10);

        // partial frame then silence longer than the timeout
        push_err();
        send_byte(8'hA5, 1'b1);
        for (int i = 0; i < 6; i++) send_byte(pl_byte(pl, i), 1'b1);
        idle(TO + 200);
        check_outputs("timeout_holds");
        good_frame(24'h123456, 16'hBEEF, 16'h0042, 16'h0007, 8'hFE);
        idle(10);

        // junk before frame; frame carries embedded sync bytes
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h3C, 1'b1);
        good_frame(24'hA5A5A5, 16'hA500, 16'h00A5, 16'h1234, 8'h01);
        idle(10);

        // bad stop bit inside a payload
        push_err();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b0);
        idle(20);
        good_frame(24'd777, 16'd3, 16'd9, 16'd27, 8'h02);
        idle(10);

        // glitch and a bad stop bit while hunting produce nothing
        rxd = 1'b0;
        @(negedge clk);
        idle(4 * CPB);
        send_byte(8'h5A, 1'b0);
        idle(20);
        check_outputs("glitch_ignored");

        for (int n = 0; n < 14; n++) begin
            logic [23:0] fp;
            logic [15:0] f1, fd, f2;
            logic [7:0]  fl;
            fp = 24'($urandom); f1 = 16'($urandom); fd = 16'($urandom);
            f2 = 16'($urandom); fl = 8'($urandom);
            if ($urandom_range(0, 3) == 0)
                bad_ck_frame({fp, f1, fd, f2, fl}, 8'(1 << $urandom_range(0, 7)));
            else
                good_frame(fp, f1, fd, f2, fl);
            idle($urandom_range(0, 40));
        end
        idle(10);
        check_outputs("random_final");

        // reset in the middle of a frame
        pl = {24'h00FFFF, 16'd1, 16'd2, 16'd3, 8'h00};
        send_byte(8'hA5, 1'b1);
        for (int i = 0; i < 4; i++) send_byte(pl_byte(pl, i), 1'b1);
        resetn = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs("reset_in_reset");
        resetn = 1'b1;
        idle(20);
        check_outputs("reset_midframe_defaults");
        good_frame(24'd42, 16'd4, 16'd8, 16'd16, 8'h01);
        idle(2 * TO);
        check_outputs("after_reset_frame");

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_strobes: %0d expected events never seen, want 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
